// File: rtl/turret_ctrl.sv
// Turret controller: aim, charge/reload, fire animation, health and death.
// Optional post-hit invulnerability window is built when TURRET_INVULN_EN is defined.
module turret_ctrl #(
  parameter int unsigned ANGLE_W       = 4,
  parameter int unsigned CHARGE_W      = 4,
  parameter int unsigned HEALTH_W      = 2,
  parameter int unsigned FIRE_CYCLES   = 830000,
  parameter int unsigned RELOAD_FAST   = 6250000,
  parameter int unsigned RELOAD_SLOW   = 12500000,
  parameter int unsigned INVULN_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fire_i,
  input  logic                change_mode_i,
  input  logic                rotate_i,
  input  logic                rotate_right_i,
  input  logic                collision_i,
  output logic [1:0]          state_o,
  output logic [CHARGE_W-1:0] charge_o,
  output logic                mode_o,
  output logic [HEALTH_W-1:0] health_o,
  output logic [ANGLE_W-1:0]  angle_o,
  output logic                firing_o,
  output logic                invuln_o
);

  localparam int unsigned FireW     = (FIRE_CYCLES > 1) ? $clog2(FIRE_CYCLES) : 1;
  localparam int unsigned ReloadMax = (RELOAD_SLOW > RELOAD_FAST) ? RELOAD_SLOW : RELOAD_FAST;
  localparam int unsigned ReloadW   = (ReloadMax > 1) ? $clog2(ReloadMax) : 1;

  localparam logic [FireW-1:0]    FireLoad   = FireW'(FIRE_CYCLES - 1);
  localparam logic [ReloadW-1:0]  FastLim    = ReloadW'(RELOAD_FAST - 1);
  localparam logic [ReloadW-1:0]  SlowLim    = ReloadW'(RELOAD_SLOW - 1);
  localparam logic [CHARGE_W-1:0] ChargeFull = '1;
  localparam logic [HEALTH_W-1:0] HealthMax  = '1;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StFiring = 2'b01,
    StDead   = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic [FireW-1:0]    fire_cnt_q, fire_cnt_d;
  logic [ReloadW-1:0]  reload_cnt_q, reload_cnt_d;
  logic [CHARGE_W-1:0] charge_q, charge_d;
  logic                mode_q, mode_d;
  logic [HEALTH_W-1:0] health_q, health_d;
  logic [ANGLE_W-1:0]  angle_q, angle_d;

  logic alive, hit_ok, hit, kill, full;
  logic [ReloadW-1:0] reload_lim;

  assign alive      = (state_q != StDead);
  assign hit        = alive & hit_ok;
  assign kill       = hit & (health_q == HEALTH_W'(1));
  assign full       = (charge_q == ChargeFull);
  assign reload_lim = mode_q ? SlowLim : FastLim;

`ifdef TURRET_INVULN_EN
  localparam int unsigned InvW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam logic [InvW-1:0] InvLoad = InvW'(INVULN_CYCLES - 1);

  logic            invuln_q, invuln_d;
  logic [InvW-1:0] inv_cnt_q, inv_cnt_d;

  assign hit_ok   = collision_i & ~invuln_q;
  assign invuln_o = invuln_q;

  always_comb begin
    invuln_d  = invuln_q;
    inv_cnt_d = inv_cnt_q;
    if (hit) begin
      invuln_d  = 1'b1;
      inv_cnt_d = InvLoad;
    end else if (invuln_q && alive) begin
      if (inv_cnt_q == '0) invuln_d = 1'b0;
      else                 inv_cnt_d = inv_cnt_q - InvW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invuln_q  <= 1'b0;
      inv_cnt_q <= '0;
    end else begin
      invuln_q  <= invuln_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end
`else
  logic unused_invuln_cycles;
  assign unused_invuln_cycles = |INVULN_CYCLES;
  assign hit_ok   = collision_i;
  assign invuln_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (fire_i && full) state_d = StFiring;
      StFiring: if (fire_cnt_q == '0) state_d = StIdle;
      StDead:   state_d = StDead;
      default:  state_d = StIdle;
    endcase
    if (kill) state_d = StDead;
  end

  always_comb begin
    state_o  = state_q;
    firing_o = (state_q == StFiring) && (fire_cnt_q == '0) && !kill;
  end

  // A fatal hit freezes everything except health, so the frozen DEAD outputs reflect pre-hit state.
  always_comb begin
    fire_cnt_d   = fire_cnt_q;
    reload_cnt_d = reload_cnt_q;
    charge_d     = charge_q;
    mode_d       = mode_q;
    angle_d      = angle_q;
    health_d     = health_q;

    if (hit && health_q != '0) health_d = health_q - HEALTH_W'(1);

    if (!kill) begin
      case (state_q)
        StIdle: begin
          if (fire_i && full) begin
            charge_d     = '0;
            fire_cnt_d   = FireLoad;
            reload_cnt_d = '0;
          end else begin
            if (!fire_i && change_mode_i) begin
              mode_d       = ~mode_q;
              reload_cnt_d = '0;
            end else if (!full) begin
              if (reload_cnt_q == reload_lim) begin
                charge_d     = charge_q + CHARGE_W'(1);
                reload_cnt_d = '0;
              end else begin
                reload_cnt_d = reload_cnt_q + ReloadW'(1);
              end
            end else begin
              reload_cnt_d = '0;
            end
            if (!fire_i && rotate_i) begin
              angle_d = rotate_right_i ? angle_q - ANGLE_W'(1) : angle_q + ANGLE_W'(1);
            end
          end
        end
        StFiring: if (fire_cnt_q != '0) fire_cnt_d = fire_cnt_q - FireW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_cnt_q   <= '0;
      reload_cnt_q <= '0;
      charge_q     <= ChargeFull;
      mode_q       <= 1'b0;
      health_q     <= HealthMax;
      angle_q      <= '0;
    end else begin
      fire_cnt_q   <= fire_cnt_d;
      reload_cnt_q <= reload_cnt_d;
      charge_q     <= charge_d;
      mode_q       <= mode_d;
      health_q     <= health_d;
      angle_q      <= angle_d;
    end
  end

  assign charge_o = charge_q;
  assign mode_o   = mode_q;
  assign health_o = health_q;
  assign angle_o  = angle_q;

endmodule

// File: tb/tb_turret_ctrl.sv
// Directed bench for turret_ctrl with short timing parameters.
// Checks the TURRET_INVULN_EN behaviour too when the macro is defined for both files.
module tb_turret_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fire, change_mode, rotate, rotate_right, collision;
  logic [1:0] state;
  logic [3:0] charge;
  logic       mode;
  logic [1:0] health;
  logic [3:0] angle;
  logic       firing, invuln;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  turret_ctrl #(
    .ANGLE_W      (4),
    .CHARGE_W     (4),
    .HEALTH_W     (2),
    .FIRE_CYCLES  (4),
    .RELOAD_FAST  (3),
    .RELOAD_SLOW  (6),
    .INVULN_CYCLES(5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fire_i        (fire),
    .change_mode_i (change_mode),
    .rotate_i      (rotate),
    .rotate_right_i(rotate_right),
    .collision_i   (collision),
    .state_o       (state),
    .charge_o      (charge),
    .mode_o        (mode),
    .health_o      (health),
    .angle_o       (angle),
    .firing_o      (firing),
    .invuln_o      (invuln)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fire = 1'b0; change_mode = 1'b0;
    rotate = 1'b0; rotate_right = 1'b0; collision = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state",  32'(state),  0);
    check_eq("rst_charge", 32'(charge), 15);
    check_eq("rst_mode",   32'(mode),   0);
    check_eq("rst_health", 32'(health), 3);
    check_eq("rst_angle",  32'(angle),  0);
    check_eq("rst_firing", 32'(firing), 0);
    check_eq("rst_invuln", 32'(invuln), 0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_after_rst", 32'(state), 0);

    // First shot: 4-cycle FIRING, pulse in its last cycle.
    fire = 1'b1; tick(); fire = 1'b0;
    check_eq("shot_state",  32'(state),  1);
    check_eq("shot_charge", 32'(charge), 0);
    check_eq("shot_firing0", 32'(firing), 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_eq("fire_pulse", 32'(firing), (k == 3) ? 32'd1 : 32'd0);
      check_eq("fire_state", 32'(state), 1);
    end
    tick();
    check_eq("back_idle",    32'(state),  0);
    check_eq("back_firing0", 32'(firing), 0);

    // Fast reload: 15 steps x 3 cycles; a fire with partial charge is ignored.
    for (int k = 1; k <= 44; k++) begin
      if (k == 10) fire = 1'b1;
      tick();
      fire = 1'b0;
      if (k == 10) check_eq("fire_not_full", 32'(state), 0);
    end
    check_eq("fast_44", 32'(charge), 14);
    tick();
    check_eq("fast_45", 32'(charge), 15);
    repeat (5) tick();
    check_eq("fast_hold", 32'(charge), 15);

    // Slow reload after change_mode: 15 steps x 6 cycles.
    fire = 1'b1; tick(); fire = 1'b0;
    repeat (4) tick();
    check_eq("shot2_idle", 32'(state), 0);
    change_mode = 1'b1; tick(); change_mode = 1'b0;
    check_eq("mode_toggled", 32'(mode),   1);
    check_eq("mode_charge",  32'(charge), 0);
    repeat (89) tick();
    check_eq("slow_89", 32'(charge), 14);
    tick();
    check_eq("slow_90", 32'(charge), 15);

    // Rotation with wrap in both directions.
    rotate = 1'b1; rotate_right = 1'b1; tick();
    check_eq("rot_right_wrap", 32'(angle), 15);
    rotate_right = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) check_eq("rot_left_wrap", 32'(angle), 0);
    end
    check_eq("rot_16", 32'(angle), 15);
    fire = 1'b1; tick(); fire = 1'b0; rotate = 1'b0;
    check_eq("rot_fire_angle", 32'(angle), 15);
    check_eq("rot_fire_state", 32'(state), 1);

    // Reset during FIRING with countdown at 2.
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_state",  32'(state),  0);
    check_eq("midrst_charge", 32'(charge), 15);
    check_eq("midrst_angle",  32'(angle),  0);
    check_eq("midrst_mode",   32'(mode),   0);
    check_eq("midrst_firing", 32'(firing), 0);
    tick();
    check_eq("midrst_firing_hold", 32'(firing), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq("no_late_pulse", 32'(firing), 0);
      check_eq("no_late_state", 32'(state),  0);
    end

    // Collisions on cycles 0 and 2.
    collision = 1'b1; tick(); collision = 1'b0;
`ifdef TURRET_INVULN_EN
    check_eq("inv_on", 32'(invuln), 1);
`endif
    tick();
    collision = 1'b1; tick(); collision = 1'b0;
`ifdef TURRET_INVULN_EN
    check_eq("inv_health", 32'(health), 2);
    repeat (2) tick();
    check_eq("inv_last", 32'(invuln), 1);
    tick();
    check_eq("inv_off", 32'(invuln), 0);
`else
    check_eq("noinv_health", 32'(health), 1);
    check_eq("noinv_flag",   32'(invuln), 0);
`endif

    // Three spaced hits kill the turret; DEAD absorbs everything.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    check_eq("rst2_health", 32'(health), 3);
    for (int h = 2; h >= 0; h--) begin
      collision = 1'b1; tick(); collision = 1'b0;
      check_eq("hit_health", 32'(health), 32'(h));
      if (h > 0) repeat (9) tick();
    end
    check_eq("dead_state",  32'(state),  2);
    check_eq("dead_firing", 32'(firing), 0);
    fire = 1'b1; rotate = 1'b1; change_mode = 1'b1;
    repeat (3) tick();
    fire = 1'b0; rotate = 1'b0; change_mode = 1'b0;
    check_eq("dead_hold_state",  32'(state),  2);
    check_eq("dead_hold_angle",  32'(angle),  0);
    check_eq("dead_hold_charge", 32'(charge), 15);
    check_eq("dead_hold_mode",   32'(mode),   0);
    check_eq("dead_hold_health", 32'(health), 0);
    check_eq("dead_hold_firing", 32'(firing), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
